ospi_psram_target: RTL and testbench

Synthesizable responder for the DDR Octal SPI PSRAM bus (APSxxxXXN X8 protocol). It decodes CE#/CK/ADQ/DQS from an octal PSRAM controller and serves linear-burst reads and byte-masked writes from an internal byte array. It is the device end of the bus and sits opposite our `hram` controller, either in simulation benches or on a loopback FPGA image. All pins are oversampled on `clk`, which must run at least 4x faster than the controller's CK toggle rate.

---
 rtl/ospi_psram_target_pkg.sv | 31 +++
 rtl/ospi_psram_target_if.sv | 29 ++
 rtl/ospi_psram_target_edge_sync.sv | 77 +++++++
 rtl/ospi_psram_target.sv | 222 ++++++++++++++++++++++
 tb/tb_ospi_psram_target.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ospi_psram_target_pkg.sv
// ---------------------------------------------------------------------------
// ospi_pkg
// Shared types and constants for the octal DDR PSRAM target model.
//   state_e          : target FSM states (also exported on the debug port)
//   CMD_*            : first command byte values understood by the target
//   CMD_EDGES        : CK edges carrying the command (byte 0 decoded, byte 1 ignored)
//   ADDR_EDGES       : CK edges carrying the 32-bit address, MSB first
//   CNT_W            : width of the per-phase CK edge counter
// ---------------------------------------------------------------------------
package ospi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        ADDR      = 3'd2,
        WLATENCY  = 3'd3,
        WDATA     = 3'd4,
        RLATENCY  = 3'd5,
        RDATA     = 3'd6,
        IGNORE    = 3'd7
    } state_e;

    localparam logic [7:0] CMD_SYNC_READ    = 8'h00;
    localparam logic [7:0] CMD_SYNC_WRITE   = 8'h80;
    localparam logic [7:0] CMD_GLOBAL_RESET = 8'hFF;

    localparam int CMD_EDGES  = 2;
    localparam int ADDR_EDGES = 4;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/ospi_psram_target_if.sv
// ---------------------------------------------------------------------------
// ospi_psram_target_if
// Pin-level octal PSRAM bus, split into the directions seen by each end.
//   ce_n, ck, adq_in, dqs_in : driven by the controller (master)
//   adq_out, adq_oe          : read data and its drive enable (slave)
//   dqs_out, dqs_oe          : read strobe and its drive enable (slave)
// ---------------------------------------------------------------------------
interface ospi_psram_target_if;

    logic       ce_n;
    logic       ck;
    logic [7:0] adq_in;
    logic       dqs_in;
    logic [7:0] adq_out;
    logic       adq_oe;
    logic       dqs_out;
    logic       dqs_oe;

    modport master (
        output ce_n, ck, adq_in, dqs_in,
        input  adq_out, adq_oe, dqs_out, dqs_oe
    );

    modport slave (
        input  ce_n, ck, adq_in, dqs_in,
        output adq_out, adq_oe, dqs_out, dqs_oe
    );

endinterface

// File: rtl/ospi_psram_target_edge_sync.sv
// ---------------------------------------------------------------------------
// ospi_edge_sync
// Oversampling front end for an OSPI slave. Registers the bus pins once, then
// produces a registered CK-edge flag together with copies of ce_n/adq/dqs that
// are aligned with that flag.
//   clk, resetn          : system clock, synchronous active-low reset
//   ce_n_pin ... dqs_pin : raw bus inputs
//   edge_det             : one-cycle pulse per CK transition while selected
//   ce_n_r, adq_r, dqs_r : pin values sampled together with the detected edge
// ---------------------------------------------------------------------------
module ospi_edge_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ce_n_pin,
    input  logic       ck_pin,
    input  logic [7:0] adq_pin,
    input  logic       dqs_pin,
    output logic       edge_det,
    output logic       ce_n_r,
    output logic [7:0] adq_r,
    output logic       dqs_r
);

    logic       ce_n_s1_q, ce_n_s1_d;
    logic       ck_s1_q,   ck_s1_d;
    logic [7:0] adq_s1_q,  adq_s1_d;
    logic       dqs_s1_q,  dqs_s1_d;
    logic       ck_s2_q,   ck_s2_d;
    logic       edge_q,    edge_d;
    logic       ce_n_q,    ce_n_d;
    logic [7:0] adq_q,     adq_d;
    logic       dqs_q,     dqs_d;

    always_comb begin
        ce_n_s1_d = ce_n_pin;
        ck_s1_d   = ck_pin;
        adq_s1_d  = adq_pin;
        dqs_s1_d  = dqs_pin;
        ck_s2_d   = ck_s1_q;
        // A CK change only counts while the chip is selected; a CK move that
        // lands together with ce_n rising is therefore never flagged.
        edge_d    = (ck_s1_q != ck_s2_q) && !ce_n_s1_q;
        ce_n_d    = ce_n_s1_q;
        adq_d     = adq_s1_q;
        dqs_d     = dqs_s1_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ce_n_s1_q <= 1'b1;
            ck_s1_q   <= 1'b0;
            adq_s1_q  <= 8'h00;
            dqs_s1_q  <= 1'b0;
            ck_s2_q   <= 1'b0;
            edge_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            adq_q     <= 8'h00;
            dqs_q     <= 1'b0;
        end else begin
            ce_n_s1_q <= ce_n_s1_d;
            ck_s1_q   <= ck_s1_d;
            adq_s1_q  <= adq_s1_d;
            dqs_s1_q  <= dqs_s1_d;
            ck_s2_q   <= ck_s2_d;
            edge_q    <= edge_d;
            ce_n_q    <= ce_n_d;
            adq_q     <= adq_d;
            dqs_q     <= dqs_d;
        end
    end

    assign edge_det = edge_q;
    assign ce_n_r   = ce_n_q;
    assign adq_r    = adq_q;
    assign dqs_r    = dqs_q;

endmodule

// File: rtl/ospi_psram_target.sv
// ---------------------------------------------------------------------------
// ospi_psram_target
// Device-side model of a DDR octal SPI PSRAM. Decodes command/address from the
// oversampled bus and serves unbounded linear read bursts and byte-masked
// write bursts from an internal byte array. All outputs are registered.
//   clk, resetn : system clock (>= 4x CK toggle rate), sync active-low reset
//   bus         : octal PSRAM pins (slave modport)
//   state       : current FSM state for debug
// Parameters: DEPTH_BYTES (power of two), WLAT, RLAT (CK edges, >= 1).
// ---------------------------------------------------------------------------
module ospi_psram_target
    import ospi_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WLAT        = 4,
    parameter int RLAT        = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    ospi_psram_target_if.slave    bus,
    output logic [2:0]            state
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic       edge_det;
    logic       ce_n_q;
    logic [7:0] adq_q;
    logic       dqs_q;

    ospi_edge_sync u_edge_sync (
        .clk      (clk),
        .resetn   (resetn),
        .ce_n_pin (bus.ce_n),
        .ck_pin   (bus.ck),
        .adq_pin  (bus.adq_in),
        .dqs_pin  (bus.dqs_in),
        .edge_det (edge_det),
        .ce_n_r   (ce_n_q),
        .adq_r    (adq_q),
        .dqs_r    (dqs_q)
    );

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [AW-1:0]    ptr_q,     ptr_d;
    logic [7:0]       cmd_q,     cmd_d;
    logic             is_wr_q,   is_wr_d;
    logic [7:0]       adq_out_q, adq_out_d;
    logic             adq_oe_q,  adq_oe_d;
    logic             dqs_out_q, dqs_out_d;
    logic             dqs_oe_q,  dqs_oe_d;
    logic             mem_we;
    logic [7:0]       rd_byte;

    logic [7:0] mem [DEPTH_BYTES];

    assign rd_byte = mem[ptr_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        cmd_d     = cmd_q;
        is_wr_d   = is_wr_q;
        adq_out_d = adq_out_q;
        adq_oe_d  = adq_oe_q;
        dqs_out_d = dqs_out_q;
        dqs_oe_d  = dqs_oe_q;
        mem_we    = 1'b0;

        if (ce_n_q) begin
            // Deselect ends any phase and releases the bus on the same edge.
            state_d   = IDLE;
            cnt_d     = '0;
            adq_oe_d  = 1'b0;
            dqs_oe_d  = 1'b0;
            dqs_out_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end

                CMD: begin
                    if (edge_det) begin
                        if (cnt_q == CNT_W'(CMD_EDGES - 1)) begin
                            // Only the first command byte is decoded.
                            cnt_d = '0;
                            if (cmd_q == CMD_SYNC_WRITE) begin
                                is_wr_d = 1'b1;
                                state_d = ADDR;
                            end else if (cmd_q == CMD_SYNC_READ) begin
                                is_wr_d = 1'b0;
                                state_d = ADDR;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            if (cnt_q == '0) begin
                                cmd_d = adq_q;
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                ADDR: begin
                    if (edge_det) begin
                        // Shifting straight into the pointer keeps only the low
                        // address bits; the upper bits fall off the top.
                        ptr_d = AW'({ptr_q, adq_q});
                        if (cnt_q == CNT_W'(ADDR_EDGES - 1)) begin
                            cnt_d = '0;
                            if (is_wr_q) begin
                                state_d = WLATENCY;
                            end else begin
                                state_d   = RLATENCY;
                                dqs_oe_d  = 1'b1;
                                dqs_out_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                WLATENCY: begin
                    if (edge_det) begin
                        if (cnt_q == CNT_W'(WLAT - 1)) begin
                            cnt_d   = '0;
                            state_d = WDATA;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                WDATA: begin
                    if (edge_det) begin
                        // DQS high masks the byte, but the pointer still moves.
                        mem_we = !dqs_q;
                        ptr_d  = ptr_q + AW'(1);
                    end
                end

                RLATENCY: begin
                    dqs_oe_d = 1'b1;
                    adq_oe_d = 1'b0;
                    if (edge_det) begin
                        if (cnt_q == CNT_W'(RLAT - 1)) begin
                            cnt_d     = '0;
                            adq_out_d = rd_byte;
                            adq_oe_d  = 1'b1;
                            dqs_out_d = 1'b1;
                            ptr_d     = ptr_q + AW'(1);
                            state_d   = RDATA;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                RDATA: begin
                    if (edge_det) begin
                        adq_out_d = rd_byte;
                        dqs_out_d = !dqs_out_q;
                        ptr_d     = ptr_q + AW'(1);
                    end
                end

                IGNORE: begin
                    adq_oe_d = 1'b0;
                    dqs_oe_d = 1'b0;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            cmd_q     <= 8'h00;
            is_wr_q   <= 1'b0;
            adq_out_q <= 8'h00;
            adq_oe_q  <= 1'b0;
            dqs_out_q <= 1'b0;
            dqs_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            cmd_q     <= cmd_d;
            is_wr_q   <= is_wr_d;
            adq_out_q <= adq_out_d;
            adq_oe_q  <= adq_oe_d;
            dqs_out_q <= dqs_out_d;
            dqs_oe_q  <= dqs_oe_d;
        end
    end

    // Backing store is not reset; a reset cycle simply blocks the write.
    always_ff @(posedge clk) begin
        if (resetn && mem_we) begin
            mem[ptr_q] <= adq_q;
        end
    end

    assign bus.adq_out = adq_out_q;
    assign bus.adq_oe  = adq_oe_q;
    assign bus.dqs_out = dqs_out_q;
    assign bus.dqs_oe  = dqs_oe_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ospi_psram_target.sv
// ---------------------------------------------------------------------------
// tb_ospi_psram_target
// Directed bench for ospi_psram_target: acts as the octal PSRAM controller,
// drives CK at 4 clk per half period and checks read data, strobes, enables
// and debug state against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ospi_psram_target;

    localparam int WLAT = 4;
    localparam int RLAT = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RLATENCY = 3'd5;
    localparam logic [2:0] S_RDATA    = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] state;
    logic       exp_dqs;
    int         total = 0;
    int         bad   = 0;

    ospi_psram_target_if bus_if ();

    ospi_psram_target #(
        .DEPTH_BYTES (1024),
        .WLAT        (WLAT),
        .RLAT        (RLAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if),
        .state  (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One CK transition carrying a byte and a DQS/mask value.
    task automatic ck_edge(input logic [7:0] d, input logic m);
        bus_if.adq_in = d;
        bus_if.dqs_in = m;
        bus_if.ck     = ~bus_if.ck;
        wait_clk(4);
    endtask

    task automatic start(input logic [7:0] cmd, input logic [31:0] addr);
        bus_if.ce_n = 1'b0;
        wait_clk(4);
        ck_edge(cmd, 1'b0);
        ck_edge(cmd, 1'b0);
        for (int i = 3; i >= 0; i--) ck_edge(addr[8*i +: 8], 1'b0);
    endtask

    task automatic stop();
        bus_if.ce_n   = 1'b1;
        bus_if.ck     = 1'b0;
        bus_if.dqs_in = 1'b0;
        wait_clk(4);
    endtask

    task automatic write4(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        start(8'h80, addr);
        repeat (WLAT) ck_edge(8'h00, 1'b0);
        for (int i = 3; i >= 0; i--) ck_edge(data[8*i +: 8], mask[i]);
        stop();
    endtask

    task automatic read_begin(input logic [31:0] addr);
        start(8'h00, addr);
        repeat (RLAT - 1) ck_edge(8'h00, 1'b0);
        exp_dqs = 1'b1;
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
        ck_edge(8'h00, 1'b0);
        chk({tag, ".adq"}, 32'(bus_if.adq_out), 32'(exp));
        chk({tag, ".dqs"}, 32'(bus_if.dqs_out), 32'(exp_dqs));
        exp_dqs = ~exp_dqs;
    endtask

    // Reads n bytes (1..4) and compares them with the top n bytes of exp.
    task automatic read_n(input string tag, input logic [31:0] addr, input int n, input logic [31:0] exp);
        read_begin(addr);
        for (int i = 0; i < n; i++) read_byte($sformatf("%s[%0d]", tag, i), exp[8*(3-i) +: 8]);
        chk({tag, ".adq_oe"}, 32'(bus_if.adq_oe), 32'd1);
        stop();
    endtask

    initial begin
        bus_if.ce_n   = 1'b1;
        bus_if.ck     = 1'b0;
        bus_if.adq_in = 8'h00;
        bus_if.dqs_in = 1'b0;
        resetn        = 1'b0;
        exp_dqs       = 1'b1;
        wait_clk(3);

        chk("rst.state",   32'(state),          32'(S_IDLE));
        chk("rst.adq_oe",  32'(bus_if.adq_oe),  32'd0);
        chk("rst.dqs_oe",  32'(bus_if.dqs_oe),  32'd0);
        chk("rst.dqs_out", 32'(bus_if.dqs_out), 32'd0);
        chk("rst.adq_out", 32'(bus_if.adq_out), 32'd0);
        resetn = 1'b1;
        wait_clk(2);

        // Write then read back, including latency-phase strobe and deselect timing.
        write4(32'h0000_0010, 32'hDEAD_BEEF, 4'b0000);
        read_begin(32'h0000_0010);
        chk("rlat.state",   32'(state),          32'(S_RLATENCY));
        chk("rlat.dqs_oe",  32'(bus_if.dqs_oe),  32'd1);
        chk("rlat.dqs_out", 32'(bus_if.dqs_out), 32'd0);
        chk("rlat.adq_oe",  32'(bus_if.adq_oe),  32'd0);
        read_byte("wr_rd[0]", 8'hDE);
        read_byte("wr_rd[1]", 8'hAD);
        read_byte("wr_rd[2]", 8'hBE);
        read_byte("wr_rd[3]", 8'hEF);
        chk("rdata.state",  32'(state),          32'(S_RDATA));
        chk("rdata.adq_oe", 32'(bus_if.adq_oe),  32'd1);
        bus_if.ce_n = 1'b1;
        bus_if.ck   = 1'b0;
        wait_clk(2);
        chk("cerise.adq_oe_hold", 32'(bus_if.adq_oe), 32'd1);
        wait_clk(1);
        chk("cerise.adq_oe",  32'(bus_if.adq_oe),  32'd0);
        chk("cerise.dqs_oe",  32'(bus_if.dqs_oe),  32'd0);
        chk("cerise.dqs_out", 32'(bus_if.dqs_out), 32'd0);
        chk("cerise.state",   32'(state),          32'(S_IDLE));
        wait_clk(2);

        // Masked write.
        write4(32'h0000_0020, 32'h1122_3344, 4'b0000);
        write4(32'h0000_0020, 32'hAABB_CCDD, 4'b1010);
        read_n("mask", 32'h0000_0020, 4, 32'h11BB_33DD);

        // Wrap-around at the top of the array.
        write4(32'd1022, 32'hA1B2_C3D4, 4'b0000);
        read_n("wrap_hi", 32'd1022, 2, 32'hA1B2_0000);
        read_n("wrap_lo", 32'd0,    2, 32'hC3D4_0000);
        read_n("wrap_all", 32'd1022, 4, 32'hA1B2_C3D4);

        // Abort in the middle of the address phase.
        bus_if.ce_n = 1'b0;
        wait_clk(4);
        ck_edge(8'h80, 1'b0);
        ck_edge(8'h80, 1'b0);
        ck_edge(8'h00, 1'b0);
        ck_edge(8'h00, 1'b0);
        stop();
        chk("abort.state", 32'(state), 32'(S_IDLE));
        read_n("abort_next", 32'h0000_0010, 4, 32'hDEAD_BEEF);

        // Unknown command: bus must stay released.
        bus_if.ce_n = 1'b0;
        wait_clk(4);
        ck_edge(8'h40, 1'b0);
        ck_edge(8'h40, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ck_edge(8'h5A, 1'(i));
            chk($sformatf("unk.adq_oe[%0d]", i), 32'(bus_if.adq_oe), 32'd0);
            chk($sformatf("unk.dqs_oe[%0d]", i), 32'(bus_if.dqs_oe), 32'd0);
        end
        chk("unk.state", 32'(state), 32'(S_IGNORE));
        stop();
        chk("unk.idle", 32'(state), 32'(S_IDLE));

        // Global reset command followed by a write-shaped tail must not write.
        start(8'hFF, 32'h0000_0020);
        repeat (WLAT) ck_edge(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) ck_edge(8'h77, 1'b0);
        chk("ff.state",  32'(state),         32'(S_IGNORE));
        chk("ff.adq_oe", 32'(bus_if.adq_oe), 32'd0);
        stop();
        read_n("ff_nochg", 32'h0000_0020, 4, 32'h11BB_33DD);

        // Reset in the middle of a read burst.
        read_begin(32'h0000_0010);
        read_byte("rstrd[0]", 8'hDE);
        read_byte("rstrd[1]", 8'hAD);
        resetn = 1'b0;
        wait_clk(1);
        chk("rstrd.adq_oe",  32'(bus_if.adq_oe),  32'd0);
        chk("rstrd.dqs_oe",  32'(bus_if.dqs_oe),  32'd0);
        chk("rstrd.dqs_out", 32'(bus_if.dqs_out), 32'd0);
        chk("rstrd.state",   32'(state),          32'(S_IDLE));
        bus_if.ce_n = 1'b1;
        bus_if.ck   = 1'b0;
        wait_clk(3);
        resetn = 1'b1;
        wait_clk(2);
        read_n("post_rst", 32'h0000_0010, 4, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
